// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data
//               access, data-side priority with fetch starvation guard and
//               a watchdog that force-completes stuck accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    localparam int c_sw = $clog2(STARVE_LIMIT + 1);
    localparam int c_tw = $clog2(TIMEOUT + 1);
    localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_LIMIT);
    localparam logic [c_tw-1:0] c_tmo_max    = c_tw'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [31:0]     m_addr_q, m_addr_d;
    logic [31:0]     m_wdata_q, m_wdata_d;
    logic [3:0]      m_wstrb_q, m_wstrb_d;
    logic            err_q, err_d;
    logic [c_sw-1:0] starve_q, starve_d;
    logic [c_tw-1:0] tmo_q, tmo_d;

    logic w_busy, w_tmo_hit, w_done, w_arb;
    logic w_i_cand, w_d_cand, w_grant_i, w_grant_d;

    always_comb begin
        w_busy    = (state_q != IDLE);
        w_tmo_hit = w_busy && !m_ready && (tmo_q == c_tmo_max);
        w_done    = w_busy && (m_ready || w_tmo_hit);
        w_arb     = !w_busy || w_done;
        // The side that is completing this cycle cannot win the next grant.
        w_i_cand  = w_arb && i_req && (state_q != BUSY_I);
        w_d_cand  = w_arb && d_req && (state_q != BUSY_D);
        w_grant_d = w_d_cand && !(w_i_cand && (starve_q == c_starve_max));
        w_grant_i = w_i_cand && !w_grant_d;

        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        tmo_d     = tmo_q;
        err_d     = err_q | w_tmo_hit;
        starve_d  = starve_q;

        if (w_grant_d) begin
            state_d   = BUSY_D;
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_we ? d_wstrb : 4'b0000;
            tmo_d     = '0;
        end else if (w_grant_i) begin
            state_d   = BUSY_I;
            m_req_d   = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wstrb_d = 4'b0000;
            tmo_d     = '0;
        end else if (w_done) begin
            state_d   = IDLE;
            m_req_d   = 1'b0;
            m_we_d    = 1'b0;
            m_wstrb_d = 4'b0000;
        end else if (w_busy) begin
            tmo_d     = tmo_q + c_tw'(1);
        end

        if (!i_req || w_grant_i) begin
            starve_d = '0;
        end else if (w_grant_d && (starve_q != c_starve_max)) begin
            starve_d = starve_q + c_sw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= 4'b0000;
            err_q     <= 1'b0;
            starve_q  <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            err_q     <= err_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
        end
    end

    // A forced completion returns zero data rather than whatever is on m_rdata.
    assign i_valid   = w_done && (state_q == BUSY_I);
    assign d_valid   = w_done && (state_q == BUSY_D);
    assign i_rdata   = (i_valid && m_ready) ? m_rdata : '0;
    assign d_rdata   = (d_valid && m_ready) ? m_rdata : '0;
    assign stall_if  = i_req & ~i_valid;
    assign stall_mem = d_req & ~d_valid;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a memory model and
//               a transaction-level arbitration reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int SL  = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        i_valid, d_valid, m_req, m_we, stall_if, stall_mem, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h13 : ((a * 32'h9E3779B1) ^ 32'h5A5A_0F0F);
    endfunction

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    logic [31:0] i_exp_q[$], d_exp_q[$];
    acc_t        acc_q[$];

    bit mdl_on = 0, prev_done = 0, mem_stuck = 0, mem_noise = 0;
    int mem_lat = -1;

    // Memory: answers each held request after a chosen number of wait cycles.
    bit mem_active = 0;
    int mem_cnt = 0, mem_tgt = 0;
    always @(posedge clk) begin
        #1;
        if (!m_req || prev_done) mem_active = 0;
        if (!m_req) begin
            m_ready = mem_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            m_rdata = $urandom;
        end else begin
            if (!mem_active) begin
                mem_active = 1;
                mem_cnt    = 0;
                mem_tgt    = mem_stuck ? (1 << 30) : (mem_lat >= 0 ? mem_lat : int'($urandom_range(0, 3)));
            end
            m_ready = (mem_cnt == mem_tgt);
            mem_cnt++;
            m_rdata = m_ready ? memfn(m_addr) : $urandom;
        end
    end

    // Monitor and reference: who owns the port, how long it has waited,
    // how many data grants fetch has sat through.
    int owner = 0, waited = 0, starve = 0;
    bit err_m = 0, in_acc = 0;
    acc_t cur;
    always @(negedge clk) begin : mon
        bit done, ic, dc, gi, gd;
        acc_t a;
        if (mdl_on) begin
            if (m_req && (!in_acc || prev_done)) begin
                if (acc_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL acc_start: unexpected access addr=%h", m_addr);
                end else cur = acc_q.pop_front();
            end
            if (m_req) begin
                chk("m_we", m_we, cur.we);
                chk("m_addr", m_addr, cur.addr);
                chk("m_wstrb", m_wstrb, cur.wstrb);
                if (cur.we) chk("m_wdata", m_wdata, cur.wdata);
            end
            in_acc = m_req;

            if (i_valid) begin
                if (i_exp_q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL i_resp: unexpected i_valid");
                end else chk("i_rdata", i_rdata, i_exp_q.pop_front());
            end
            if (d_valid) begin
                if (d_exp_q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL d_resp: unexpected d_valid");
                end else chk("d_rdata", d_rdata, d_exp_q.pop_front());
            end

            done = (owner != 0) && (m_ready || waited == TMO);
            chk("m_req", m_req, owner != 0);
            chk("i_valid", i_valid, done && owner == 1);
            chk("d_valid", d_valid, done && owner == 2);
            chk("stall_if", stall_if, i_req && !(done && owner == 1));
            chk("stall_mem", stall_mem, d_req && !(done && owner == 2));
            chk("err", err, err_m);

            if (reset) begin
                owner = 0; waited = 0; starve = 0; err_m = 0;
            end else begin
                if (done && !m_ready) err_m = 1;
                gi = 0; gd = 0;
                if (owner == 0 || done) begin
                    ic = i_req && owner != 1;
                    dc = d_req && owner != 2;
                    gd = dc && !(ic && starve == SL);
                    gi = ic && !gd;
                end
                if (!i_req || gi) starve = 0;
                else if (gd && starve < SL) starve++;
                if (gd) begin
                    a = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: (d_we ? d_wstrb : 4'b0000)};
                    acc_q.push_back(a); owner = 2; waited = 0;
                end else if (gi) begin
                    a = '{we: 1'b0, addr: i_addr, wdata: 32'h0, wstrb: 4'b0000};
                    acc_q.push_back(a); owner = 1; waited = 0;
                end else if (done) owner = 0;
                else if (owner != 0) waited++;
            end
        end
        prev_done = i_valid | d_valid;
    end

    // Waits for the chosen side's valid, counting m_req and stall cycles on the way.
    task automatic wait_valid(input bit side, output int mreq_cyc, output int stall_cyc);
        mreq_cyc = 0; stall_cyc = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            mreq_cyc  += int'(m_req);
            stall_cyc += int'(side ? stall_mem : stall_if);
            if (side ? d_valid : i_valid) begin
                @(posedge clk); #1;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL %s_wait: no valid within 300 cycles", side ? "d" : "i");
    endtask

    task automatic run_i(input int n, input int maxgap);
        int a, b;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            i_addr = 32'($urandom_range(0, 1023)) << 2;
            i_req  = 1;
            i_exp_q.push_back(memfn(i_addr));
            wait_valid(0, a, b);
            i_req = 0;
        end
    endtask

    task automatic run_d(input int n, input int maxgap);
        int a, b;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(1, 15));
            d_req   = 1;
            d_exp_q.push_back(memfn(d_addr));
            wait_valid(1, a, b);
            d_req = 0;
        end
    endtask

    initial begin
        int mc, sc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wstrb", m_wstrb, 0);
        chk("rst_err", err, 0);
        reset  = 0;
        mdl_on = 1;

        // Lone fetch, memory ready on the second request cycle.
        mem_lat = 1;
        i_addr  = 32'h100; i_req = 1; i_exp_q.push_back(32'h13);
        wait_valid(0, mc, sc);
        i_req = 0;
        chk("fetch_mreq_cycles", mc, 2);
        chk("fetch_stall_cycles", sc, 2);

        // Simultaneous store and fetch, single-cycle memory.
        mem_lat = 0;
        d_we = 1; d_addr = 32'h2000; d_wdata = 32'hCAFEBABE; d_wstrb = 4'hF; d_req = 1;
        i_addr = 32'h200; i_req = 1;
        d_exp_q.push_back(memfn(32'h2000));
        i_exp_q.push_back(memfn(32'h200));
        @(negedge clk);
        @(negedge clk);
        chk("sim_d_first_we", m_we, 1);
        chk("sim_d_first_addr", m_addr, 32'h2000);
        chk("sim_d_valid", d_valid, 1);
        @(posedge clk); #1; d_req = 0;
        @(negedge clk);
        chk("sim_i_next_req", m_req, 1);
        chk("sim_i_next_addr", m_addr, 32'h200);
        chk("sim_i_valid", i_valid, 1);
        @(posedge clk); #1; i_req = 0;

        // Byte store held for several cycles.
        mem_lat = 2;
        d_we = 1; d_addr = 32'h3001; d_wdata = 32'h0000_AB00; d_wstrb = 4'b0010; d_req = 1;
        d_exp_q.push_back(memfn(32'h3001));
        wait_valid(1, mc, sc);
        d_req = 0;
        chk("bytestore_mreq_cycles", mc, 3);

        // Stuck memory: watchdog completes the load with zero data.
        mem_stuck = 1;
        d_we = 0; d_addr = 32'h40; d_req = 1;
        d_exp_q.push_back(32'h0);
        wait_valid(1, mc, sc);
        d_req = 0;
        chk("tmo_mreq_cycles", mc, TMO + 1);
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", err, 1);

        // Reset while a load is outstanding; request is re-granted afterwards.
        @(posedge clk); #1;
        d_we = 0; d_addr = 32'h80; d_req = 1;
        d_exp_q.push_back(memfn(32'h80));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1; mem_stuck = 0; mem_lat = -1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rstmid_m_req", m_req, 0);
        chk("rstmid_err", err, 0);
        chk("rstmid_d_valid", d_valid, 0);
        wait_valid(1, mc, sc);
        d_req = 0;

        // Random traffic, then back-to-back traffic from both sides.
        mem_noise = 1;
        fork
            run_i(60, 4);
            run_d(60, 4);
        join
        fork
            run_i(25, 0);
            run_d(25, 0);
        join
        mem_noise = 0;
        repeat (5) @(negedge clk);
        chk("i_queue_empty", i_exp_q.size(), 0);
        chk("d_queue_empty", d_exp_q.size(), 0);
        chk("acc_queue_empty", acc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
